sr_axi_burst_adapter: RTL and testbench

Bridges the single-outstanding CPU memory request/response port to an AXI master port, serialising one MEM_DATA_WIDTH word into an INCR burst of AXI_DATA_WIDTH beats. Adds byte enables, a configurable transaction ID and error reporting from BRESP/RRESP/RLAST. Sits between `sr_cpu` and the NoC AXI interface inside the CPU tile wrapper.

---
 rtl/sr_axi_adapter_pkg.sv | 80 ++++++++
 rtl/sr_axi_burst_adapter.sv | 164 ++++++++++++++++
 tb/tb_sr_axi_burst_adapter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sr_axi_adapter_pkg.sv
// Shared types for the CPU-port to AXI burst adapter: FSM states, AXI channel
// bundles and the burst/response encodings used on them.
package sr_axi_adapter_pkg;

  localparam int AXI_ADDR_W   = 16;
  localparam int AXI_DATA_W   = 8;
  localparam int AXI_STRB_W   = AXI_DATA_W / 8;
  localparam int MAX_ID_WIDTH = 4;
  localparam int USER_W       = 4;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW   = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_B    = 3'd3,
    ST_RD_AR   = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_RESP    = 3'd6
  } state_e;

  typedef struct packed {
    logic [MAX_ID_WIDTH-1:0] awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [USER_W-1:0]       awuser;
    logic                    awvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_STRB_W-1:0]   wstrb;
    logic                    wlast;
    logic [USER_W-1:0]       wuser;
    logic                    wvalid;
    logic                    bready;
    logic [MAX_ID_WIDTH-1:0] arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [USER_W-1:0]       aruser;
    logic                    arvalid;
    logic                    rready;
  } axi_mosi_t;

  typedef struct packed {
    logic                    awready;
    logic                    wready;
    logic [MAX_ID_WIDTH-1:0] bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    arready;
    logic [MAX_ID_WIDTH-1:0] rid;
    logic [AXI_DATA_W-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
  } axi_miso_t;

  function automatic int beats_f(input int mem_w, input int axi_w);
    return mem_w / axi_w;
  endfunction

  function automatic logic [2:0] axsize_f(input int axi_w);
    return 3'($clog2(axi_w / 8));
  endfunction

endpackage

// File: rtl/sr_axi_burst_adapter.sv
// Single-outstanding CPU memory port to AXI master: one CPU word becomes one
// INCR burst of narrow beats, with ID/response checking folded into mem_err_o.
module sr_axi_burst_adapter
  import sr_axi_adapter_pkg::*;
#(
  parameter int ADDR_WIDTH     = AXI_ADDR_W,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = AXI_DATA_W,
  parameter int ID_W_WIDTH     = 4,
  parameter int ID_R_WIDTH     = 4,
  parameter logic [MAX_ID_WIDTH-1:0] TXN_ID = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_wr_i,
  input  logic [ADDR_WIDTH-1:0]       mem_addr_i,
  input  logic [MEM_DATA_WIDTH/8-1:0] mem_be_i,
  input  logic [MEM_DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic                        mem_req_valid_i,
  output logic                        mem_req_ready_o,
  output logic                        mem_resp_valid_o,
  input  logic                        mem_resp_ready_i,
  output logic [MEM_DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                        mem_err_o,
  input  axi_miso_t                   in_miso_i,
  output axi_mosi_t                   in_mosi_o
);

  localparam int BEATS    = beats_f(MEM_DATA_WIDTH, AXI_DATA_WIDTH);
  localparam int BE_W     = MEM_DATA_WIDTH / 8;
  localparam int AXI_BE_W = AXI_DATA_WIDTH / 8;
  localparam int CNT_W    = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] SAT_BEAT  = CNT_W'(BEATS);
  localparam logic [7:0]       AX_LEN    = 8'(BEATS - 1);
  localparam logic [2:0]       AX_SIZE   = axsize_f(AXI_DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(BE_W - 1);
  localparam logic [MAX_ID_WIDTH-1:0] ID_W_MASK = MAX_ID_WIDTH'((64'd1 << ID_W_WIDTH) - 64'd1);
  localparam logic [MAX_ID_WIDTH-1:0] ID_R_MASK = MAX_ID_WIDTH'((64'd1 << ID_R_WIDTH) - 64'd1);

  state_e                    state_r, state_s;
  logic [ADDR_WIDTH-1:0]     addr_r;
  logic [BE_W-1:0]           be_r;
  logic [MEM_DATA_WIDTH-1:0] wdata_r, rdata_r;
  logic [CNT_W-1:0]          beat_r, beat_idx_s;
  logic                      err_r;
  logic req_hs_s, aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic last_beat_s, b_err_s, r_err_s;
  int                        data_ofs_s, strb_ofs_s;
  axi_mosi_t                 mosi_s;

  // Handshake qualifiers, beat slice offsets and per-response error terms
  always_comb begin
    req_hs_s    = (state_r == ST_IDLE) && mem_req_valid_i;
    aw_hs_s     = (state_r == ST_WR_AW) && in_miso_i.awready;
    w_hs_s      = (state_r == ST_WR_DATA) && in_miso_i.wready;
    b_hs_s      = (state_r == ST_WR_B) && in_miso_i.bvalid;
    ar_hs_s     = (state_r == ST_RD_AR) && in_miso_i.arready;
    r_hs_s      = (state_r == ST_RD_DATA) && in_miso_i.rvalid;
    last_beat_s = (beat_r == LAST_BEAT);
    beat_idx_s  = (beat_r < SAT_BEAT) ? beat_r : LAST_BEAT;
    data_ofs_s  = int'(beat_idx_s) * AXI_DATA_WIDTH;
    strb_ofs_s  = int'(beat_idx_s) * AXI_BE_W;
    b_err_s     = (in_miso_i.bresp inside {RESP_SLVERR, RESP_DECERR}) ||
                  (((in_miso_i.bid ^ TXN_ID) & ID_W_MASK) != '0);
    // Count saturates at BEATS, so any beat seen there is a surplus beat
    r_err_s     = (in_miso_i.rresp inside {RESP_SLVERR, RESP_DECERR}) ||
                  (((in_miso_i.rid ^ TXN_ID) & ID_R_MASK) != '0) ||
                  (in_miso_i.rlast && !last_beat_s) ||
                  (beat_r == SAT_BEAT);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:    if (req_hs_s) state_s = mem_wr_i ? ST_WR_AW : ST_RD_AR;
                  else          state_s = ST_IDLE;
      ST_WR_AW:   if (aw_hs_s) state_s = ST_WR_DATA; else state_s = ST_WR_AW;
      ST_WR_DATA: if (w_hs_s && last_beat_s) state_s = ST_WR_B; else state_s = ST_WR_DATA;
      ST_WR_B:    if (b_hs_s) state_s = ST_RESP; else state_s = ST_WR_B;
      ST_RD_AR:   if (ar_hs_s) state_s = ST_RD_DATA; else state_s = ST_RD_AR;
      ST_RD_DATA: if (r_hs_s && in_miso_i.rlast) state_s = ST_RESP; else state_s = ST_RD_DATA;
      ST_RESP:    if (mem_resp_ready_i) state_s = ST_IDLE; else state_s = ST_RESP;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Request capture, beat counter, read-data assembly and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= '0;
      be_r    <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      beat_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_hs_s) begin
            addr_r  <= mem_addr_i & ADDR_MASK;
            be_r    <= mem_be_i;
            wdata_r <= mem_wdata_i;
            rdata_r <= '0;
            beat_r  <= '0;
            err_r   <= 1'b0;
          end
        end
        ST_WR_DATA: if (w_hs_s) beat_r <= beat_r + CNT_W'(1);
        ST_WR_B:    if (b_hs_s) err_r <= err_r | b_err_s;
        ST_RD_DATA: begin
          if (r_hs_s) begin
            if (beat_r < SAT_BEAT) begin
              rdata_r[data_ofs_s +: AXI_DATA_WIDTH] <= in_miso_i.rdata;
              beat_r <= beat_r + CNT_W'(1);
            end
            err_r <= err_r | r_err_s;
          end
        end
        default: ;
      endcase
    end
  end

  // AXI channel outputs decoded from registered state and payload
  always_comb begin
    mosi_s         = '0;
    mosi_s.awid    = TXN_ID & ID_W_MASK;
    mosi_s.awaddr  = AXI_ADDR_W'(addr_r);
    mosi_s.awlen   = AX_LEN;
    mosi_s.awsize  = AX_SIZE;
    mosi_s.awburst = BURST_INCR;
    mosi_s.arid    = TXN_ID & ID_R_MASK;
    mosi_s.araddr  = AXI_ADDR_W'(addr_r);
    mosi_s.arlen   = AX_LEN;
    mosi_s.arsize  = AX_SIZE;
    mosi_s.arburst = BURST_INCR;
    mosi_s.wdata   = wdata_r[data_ofs_s +: AXI_DATA_WIDTH];
    mosi_s.wstrb   = be_r[strb_ofs_s +: AXI_BE_W];
    mosi_s.wlast   = last_beat_s;
    case (state_r)
      ST_WR_AW:   mosi_s.awvalid = 1'b1;
      ST_WR_DATA: mosi_s.wvalid  = 1'b1;
      ST_WR_B:    mosi_s.bready  = 1'b1;
      ST_RD_AR:   mosi_s.arvalid = 1'b1;
      ST_RD_DATA: mosi_s.rready  = 1'b1;
      default:    mosi_s.bready  = 1'b0;
    endcase
  end

  assign in_mosi_o        = mosi_s;
  assign mem_req_ready_o  = (state_r == ST_IDLE);
  assign mem_resp_valid_o = (state_r == ST_RESP);
  assign mem_rdata_o      = rdata_r;
  assign mem_err_o        = err_r;

endmodule

// File: tb/tb_sr_axi_burst_adapter.sv
// Self-checking bench: the bench acts as the AXI slave and the CPU, runs a
// directed table, a reset-abort sequence and random transactions.
module tb_sr_axi_burst_adapter;
  import sr_axi_adapter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        mem_wr, mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready, mem_err;
  logic [15:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  axi_miso_t   miso;
  axi_mosi_t   mosi;

  sr_axi_burst_adapter dut (
    .clk(clk), .rst_n(rst_n), .mem_wr_i(mem_wr), .mem_addr_i(mem_addr),
    .mem_be_i(mem_be), .mem_wdata_i(mem_wdata), .mem_req_valid_i(mem_req_valid),
    .mem_req_ready_o(mem_req_ready), .mem_resp_valid_o(mem_resp_valid),
    .mem_resp_ready_i(mem_resp_ready), .mem_rdata_o(mem_rdata), .mem_err_o(mem_err),
    .in_miso_i(miso), .in_mosi_o(mosi)
  );

  typedef struct {
    string       name;
    bit          wr;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          aw_delay;
    bit          w_alt;
    int          resp_delay;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    int          rlast_at;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    int          rst_after;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input bit wr, input logic [15:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int aw_delay, input bit w_alt,
                              input int resp_delay, input logic [1:0] bresp, input logic [3:0] bid,
                              input int rlast_at, input logic [1:0] rresp, input logic [3:0] rid,
                              input logic [31:0] exp_rdata, input bit exp_err, input int exp_lat);
    vec_t v;
    v.name = n; v.wr = wr; v.addr = addr; v.be = be; v.wdata = wdata; v.rdata = rdata;
    v.aw_delay = aw_delay; v.w_alt = w_alt; v.resp_delay = resp_delay; v.bresp = bresp;
    v.bid = bid; v.rlast_at = rlast_at; v.rresp = rresp; v.rid = rid; v.rst_after = -1;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  // Byte the slave returns on read beat k; beats past the word carry filler
  function automatic logic [7:0] rbyte(input vec_t v, input int k);
    if (k < 4) return v.rdata[k*8 +: 8];
    return 8'hE0 + 8'(k);
  endfunction

  // Reference model: the response the CPU should see for a transaction
  function automatic void model(inout vec_t v);
    int n;
    v.exp_rdata = 32'h0;
    if (v.wr) begin
      v.exp_err = v.bresp[1] || (v.bid != 4'd0);
    end else begin
      n = (v.rlast_at + 1 < 4) ? v.rlast_at + 1 : 4;
      for (int k = 0; k < n; k++) v.exp_rdata[k*8 +: 8] = rbyte(v, k);
      v.exp_err = v.rresp[1] || (v.rid != 4'd0) || (v.rlast_at != 3);
    end
    v.exp_lat = 0;
  endfunction

  task automatic run(input vec_t v);
    int cyc = 0, ax_wait = 0, resp_wait = 0, nr = 0, proto = 0, resp_cyc = -1;
    bit ax_seen = 0, ax_done = 0, wl_done = 0, b_done = 0, r_done = 0, resp_seen = 0, done = 0;
    logic [15:0] ax_addr; logic [7:0] ax_len; logic [2:0] ax_size; logic [1:0] ax_burst;
    logic [3:0]  ax_id;
    logic [7:0]  wd[$]; logic ws[$]; logic wl[$];
    logic [31:0] r0; logic e0;
    @(negedge clk);
    chk({v.name, ".req_ready"}, mem_req_ready, 1);
    mem_req_valid = 1'b1; mem_wr = v.wr; mem_addr = v.addr; mem_be = v.be; mem_wdata = v.wdata;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      mem_req_valid = 1'b0; mem_wdata = $urandom; mem_addr = 16'($urandom); mem_be = 4'($urandom);
      miso = '0; mem_resp_ready = 1'b0;
      if (mem_req_ready) proto++;
      if (wl_done && !b_done) begin
        miso.bvalid = 1'b1; miso.bresp = v.bresp; miso.bid = v.bid;
        if (mosi.bready) b_done = 1;
      end
      if (mosi.wvalid) begin
        if (!ax_done || wl_done) proto++;
        miso.wready = v.w_alt ? cyc[0] : 1'b1;
        if (miso.wready) begin
          wd.push_back(mosi.wdata); ws.push_back(mosi.wstrb[0]); wl.push_back(mosi.wlast);
          if (mosi.wlast) wl_done = 1;
        end
      end
      if (ax_done && !v.wr && !r_done) begin
        if (v.rst_after >= 0 && nr == v.rst_after) begin
          rst_n = 1'b0;
          #1;
          chk({v.name, ".rst_rready"}, mosi.rready, 0);
          chk({v.name, ".rst_arvalid"}, mosi.arvalid, 0);
          chk({v.name, ".rst_req_ready"}, mem_req_ready, 1);
          chk({v.name, ".rst_resp_valid"}, mem_resp_valid, 0);
          miso = '0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        miso.rvalid = 1'b1; miso.rdata = rbyte(v, nr); miso.rlast = (nr == v.rlast_at);
        miso.rid = v.rid; miso.rresp = v.rresp;
        if (mosi.rready) begin
          nr++;
          if (miso.rlast) r_done = 1;
        end
      end
      if (mosi.awvalid || mosi.arvalid) begin
        if (ax_done || (mosi.awvalid && !v.wr) || (mosi.arvalid && v.wr)) proto++;
        if (!ax_seen) begin
          ax_seen = 1;
          {ax_addr, ax_len, ax_size, ax_burst, ax_id} = v.wr ?
            {mosi.awaddr, mosi.awlen, mosi.awsize, mosi.awburst, mosi.awid} :
            {mosi.araddr, mosi.arlen, mosi.arsize, mosi.arburst, mosi.arid};
        end else if ((v.wr ? mosi.awaddr : mosi.araddr) !== ax_addr) proto++;
        if (ax_wait >= v.aw_delay) begin
          if (v.wr) miso.awready = 1'b1; else miso.arready = 1'b1;
          ax_done = 1;
        end
        ax_wait++;
      end
      if (mem_resp_valid) begin
        if (!resp_seen) begin resp_seen = 1; r0 = mem_rdata; e0 = mem_err; resp_cyc = cyc; end
        else if (mem_rdata !== r0 || mem_err !== e0) proto++;
        if (resp_wait >= v.resp_delay) begin mem_resp_ready = 1'b1; done = 1; end
        resp_wait++;
      end
    end
    @(negedge clk);
    miso = '0; mem_resp_ready = 1'b0;
    chk({v.name, ".completed"}, done, 1);
    if (!done) begin
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      return;
    end
    chk({v.name, ".idle_after"}, {mem_req_ready, mem_resp_valid}, 2'b10);
    chk({v.name, ".ax_addr"}, ax_addr, v.addr & 16'hFFFC);
    chk({v.name, ".ax_len_size_burst_id"}, {ax_len, ax_size, ax_burst, ax_id}, {8'd3, 3'd0, 2'b01, 4'd0});
    if (v.wr) begin
      chk({v.name, ".w_beats"}, wd.size(), 4);
      for (int k = 0; k < 4 && k < wd.size(); k++) begin
        chk($sformatf("%s.w%0d_data", v.name, k), wd[k], v.wdata[k*8 +: 8]);
        chk($sformatf("%s.w%0d_strb_last", v.name, k), {ws[k], wl[k]}, {v.be[k], k == 3});
      end
    end else begin
      chk({v.name, ".r_beats"}, nr, v.rlast_at + 1);
    end
    chk({v.name, ".rdata"}, r0, v.exp_rdata);
    chk({v.name, ".err"}, e0, v.exp_err);
    chk({v.name, ".protocol"}, proto, 0);
    if (v.exp_lat > 0) chk({v.name, ".latency"}, resp_cyc, v.exp_lat);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    mem_wr = 1'b0; mem_req_valid = 1'b0; mem_resp_ready = 1'b0; mem_addr = '0;
    mem_be = '0; mem_wdata = '0; miso = '0;
    repeat (3) @(negedge clk);
    chk("reset.mem_side", {mem_req_ready, mem_resp_valid, mem_err, mem_rdata}, {3'b100, 32'h0});
    chk("reset.axi_valids", {mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid, mosi.rready}, 5'b0);
    rst_n = 1'b1;

    tbl.push_back(mk("wr_basic", 1, 16'h0012, 4'hF, 32'hA1B2C3D4, 32'h0, 0, 0, 0, 2'b00, 4'd0, 3, 2'b00, 4'd0, 32'h0, 0, 7));
    tbl.push_back(mk("rd_basic", 0, 16'h0040, 4'h0, 32'h0, 32'h44332211, 0, 0, 0, 2'b00, 4'd0, 3, 2'b00, 4'd0, 32'h44332211, 0, 6));
    tbl.push_back(mk("wr_be6", 1, 16'h0100, 4'h6, 32'h55667788, 32'h0, 0, 0, 0, 2'b00, 4'd0, 3, 2'b00, 4'd0, 32'h0, 0, 7));
    tbl.push_back(mk("wr_bp", 1, 16'h0207, 4'hF, 32'h0BADF00D, 32'h0, 5, 1, 3, 2'b00, 4'd0, 3, 2'b00, 4'd0, 32'h0, 0, 0));
    tbl.push_back(mk("rd_bp", 0, 16'h0303, 4'h0, 32'h0, 32'hCAFEBABE, 5, 0, 3, 2'b00, 4'd0, 3, 2'b00, 4'd0, 32'hCAFEBABE, 0, 0));
    tbl.push_back(mk("wr_slverr", 1, 16'h0010, 4'hF, 32'h12345678, 32'h0, 0, 0, 0, 2'b10, 4'd0, 3, 2'b00, 4'd0, 32'h0, 1, 7));
    tbl.push_back(mk("wr_exokay", 1, 16'h0014, 4'h9, 32'h9ABCDEF0, 32'h0, 0, 0, 0, 2'b01, 4'd0, 3, 2'b00, 4'd0, 32'h0, 0, 7));
    tbl.push_back(mk("wr_bid3", 1, 16'h0018, 4'hF, 32'h0F0F0F0F, 32'h0, 0, 0, 0, 2'b00, 4'd3, 3, 2'b00, 4'd0, 32'h0, 1, 7));
    tbl.push_back(mk("rd_short", 0, 16'h0040, 4'h0, 32'h0, 32'h44332211, 0, 0, 0, 2'b00, 4'd0, 1, 2'b00, 4'd0, 32'h00002211, 1, 0));
    tbl.push_back(mk("rd_rid5", 0, 16'h0044, 4'h0, 32'h0, 32'h88776655, 0, 0, 0, 2'b00, 4'd0, 3, 2'b00, 4'd5, 32'h88776655, 1, 6));
    tbl.push_back(mk("rd_long", 0, 16'h0048, 4'h0, 32'h0, 32'hDDCCBBAA, 0, 0, 0, 2'b00, 4'd0, 5, 2'b00, 4'd0, 32'hDDCCBBAA, 1, 0));
    tbl.push_back(mk("rd_slverr", 0, 16'h004C, 4'h0, 32'h0, 32'h01020304, 0, 0, 0, 2'b00, 4'd0, 3, 2'b10, 4'd0, 32'h01020304, 1, 6));
    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // Reset after two read beats, then a clean read must still work
    v = mk("rd_reset", 0, 16'h0080, 4'h0, 32'h0, 32'h44332211, 0, 0, 0, 2'b00, 4'd0, 3, 2'b00, 4'd0, 32'h0, 0, 0);
    v.rst_after = 2;
    run(v);
    repeat (2) @(negedge clk);
    chk("rd_reset.quiet", {mosi.arvalid, mosi.rready, mem_resp_valid, mem_req_ready}, 4'b0001);
    run(mk("rd_after_reset", 0, 16'h0084, 4'h0, 32'h0, 32'h5A6B7C8D, 0, 0, 0, 2'b00, 4'd0, 3, 2'b00, 4'd0, 32'h5A6B7C8D, 0, 6));

    for (int i = 0; i < 40; i++) begin
      v = mk($sformatf("rand%0d", i), 1'($urandom), 16'($urandom), 4'($urandom), $urandom, $urandom,
             $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
             ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0,
             ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : 3,
             ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00,
             ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0, 32'h0, 0, 0);
      model(v);
      run(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
